// File: rtl/ysyx_clint.sv
// Core-local interruptor: free-running 64-bit mtime, mtimecmp compare register and msip bit,
// reachable from the LSU over a single-cycle valid/response load/store handshake.
module ysyx_clint #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] BASE     = 32'h0200_0000,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] araddr,
    input  logic            arvalid,
    output logic [XLEN-1:0] rdata,
    output logic            rvalid,
    input  logic [XLEN-1:0] awaddr,
    input  logic            awvalid,
    input  logic [XLEN-1:0] wdata,
    input  logic [3:0]      wstrb,
    input  logic            wvalid,
    output logic            wready,
    output logic            out_mtip,
    output logic            out_msip,
    output logic [63:0]     out_mtime
);

    typedef enum logic [2:0] {
        RegNone,
        RegMsip,
        RegCmpLo,
        RegCmpHi,
        RegTimeLo,
        RegTimeHi
    } reg_sel_e;

    localparam logic [7:0] PreMax = 8'(TICK_DIV - 1);

    logic [7:0]  pre_q, pre_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        mtip_q;
    logic [31:0] rdata_q;
    logic        rvalid_q;
    logic        wready_q;

    logic        tick;
    logic        lo_carry;
    logic [31:0] lo_inc;
    logic [31:0] hi_inc;
    logic        wr_fire;
    reg_sel_e    wr_sel;
    reg_sel_e    rd_sel;
    logic [31:0] rd_val;

    // Address bits [1:0] select a byte within a word and are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{araddr[1:0], awaddr[1:0]};

    function automatic reg_sel_e decode(input logic [31:0] addr);
        reg_sel_e sel;
        sel = RegNone;
        if (addr[31:16] == BASE[31:16]) begin
            unique case (addr[15:2])
                14'h0000: sel = RegMsip;
                14'h1000: sel = RegCmpLo;
                14'h1001: sel = RegCmpHi;
                14'h2FFE: sel = RegTimeLo;
                14'h2FFF: sel = RegTimeHi;
                default:  sel = RegNone;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = data[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign wr_fire = awvalid && wvalid;
    assign wr_sel  = decode(awaddr[31:0]);
    assign rd_sel  = decode(araddr[31:0]);

    always_comb begin
        tick  = (pre_q == PreMax);
        pre_d = tick ? 8'd0 : pre_q + 8'd1;

        // The upper half only ever sees the carry of the pre-write lower half.
        {lo_carry, lo_inc} = {1'b0, mtime_q[31:0]} + {32'd0, tick};
        hi_inc             = mtime_q[63:32] + {31'd0, lo_carry};

        mtime_d    = {hi_inc, lo_inc};
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;

        if (wr_fire) begin
            unique case (wr_sel)
                RegMsip: begin
                    if (wstrb[0]) begin
                        msip_d = wdata[0];
                    end
                end
                RegCmpLo:  mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wdata[31:0], wstrb);
                RegCmpHi:  mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wdata[31:0], wstrb);
                RegTimeLo: mtime_d[31:0]     = merge(lo_inc, wdata[31:0], wstrb);
                RegTimeHi: mtime_d[63:32]    = merge(hi_inc, wdata[31:0], wstrb);
                default:   ;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        unique case (rd_sel)
            RegMsip:   rd_val = {31'd0, msip_q};
            RegCmpLo:  rd_val = mtimecmp_q[31:0];
            RegCmpHi:  rd_val = mtimecmp_q[63:32];
            RegTimeLo: rd_val = mtime_q[31:0];
            RegTimeHi: rd_val = mtime_q[63:32];
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q      <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            wready_q   <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            // Compare the post-edge values so mtip has no extra cycle of lag.
            mtip_q     <= (mtime_d >= mtimecmp_d);
            rdata_q    <= arvalid ? rd_val : 32'd0;
            rvalid_q   <= arvalid;
            wready_q   <= wr_fire;
        end
    end

    assign rdata     = XLEN'(rdata_q);
    assign rvalid    = rvalid_q;
    assign wready    = wready_q;
    assign out_mtip  = mtip_q;
    assign out_msip  = msip_q;
    assign out_mtime = mtime_q;

endmodule

// File: tb/tb_ysyx_clint.sv
// Randomised scoreboard bench for ysyx_clint; instance 0 runs TICK_DIV=1, instance 1 TICK_DIV=4,
// both driven by the same bus stimulus and compared against a behavioural register model.
module tb_ysyx_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
    logic [3:0]  wstrb = '0;

    logic [1:0][31:0] rdata_o;
    logic [1:0]       rvalid_o, wready_o, mtip_o, msip_o;
    logic [1:0][63:0] mtime_o;

    int n_chk  = 0;
    int n_fail = 0;

    ysyx_clint #(.XLEN(32), .BASE(BASE), .TICK_DIV(1)) dut (
        .clock(clock), .reset(reset), .araddr(araddr), .arvalid(arvalid), .rdata(rdata_o[0]),
        .rvalid(rvalid_o[0]), .awaddr(awaddr), .awvalid(awvalid), .wdata(wdata), .wstrb(wstrb),
        .wvalid(wvalid), .wready(wready_o[0]), .out_mtip(mtip_o[0]), .out_msip(msip_o[0]),
        .out_mtime(mtime_o[0])
    );

    ysyx_clint #(.XLEN(32), .BASE(BASE), .TICK_DIV(4)) dut4 (
        .clock(clock), .reset(reset), .araddr(araddr), .arvalid(arvalid), .rdata(rdata_o[1]),
        .rvalid(rvalid_o[1]), .awaddr(awaddr), .awvalid(awvalid), .wdata(wdata), .wstrb(wstrb),
        .wvalid(wvalid), .wready(wready_o[1]), .out_mtip(mtip_o[1]), .out_msip(msip_o[1]),
        .out_mtime(mtime_o[1])
    );

    always #5 clock = ~clock;

    // Behavioural model state, one slot per instance.
    logic [63:0] m_time [2], m_cmp [2], n_time [2], n_cmp [2];
    logic        m_msip [2], m_mtip [2], n_msip [2], n_mtip [2];
    int          m_pre [2], n_pre [2];
    logic [31:0] rq [2][$];
    logic        wq [2][$];

    function automatic void chk(string name, int inst, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(int i, logic [31:0] a);
        if (a[31:16] != BASE[31:16]) return 32'd0;
        case ({a[15:2], 2'b00})
            16'h0000: return {31'd0, m_msip[i]};
            16'h4000: return m_cmp[i][31:0];
            16'h4004: return m_cmp[i][63:32];
            16'hBFF8: return m_time[i][31:0];
            16'hBFFC: return m_time[i][63:32];
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_time[i] = '0;
            m_cmp[i]  = '1;
            m_msip[i] = 1'b0;
            m_mtip[i] = 1'b0;
            m_pre[i]  = 0;
            rq[i].delete();
            wq[i].delete();
        end
    endtask

    task automatic model_step(int i);
        int          div;
        logic        tick;
        logic [63:0] t;
        div      = (i == 0) ? 1 : 4;
        tick     = (m_pre[i] == div - 1);
        n_pre[i] = tick ? 0 : m_pre[i] + 1;
        t        = m_time[i] + (tick ? 64'd1 : 64'd0);
        n_cmp[i]  = m_cmp[i];
        n_msip[i] = m_msip[i];
        if (arvalid) rq[i].push_back(m_read(i, araddr));
        if (awvalid && wvalid) begin
            wq[i].push_back(1'b1);
            if (awaddr[31:16] == BASE[31:16]) begin
                case ({awaddr[15:2], 2'b00})
                    16'h0000: if (wstrb[0]) n_msip[i] = wdata[0];
                    16'h4000: n_cmp[i][31:0]  = merge(m_cmp[i][31:0], wdata, wstrb);
                    16'h4004: n_cmp[i][63:32] = merge(m_cmp[i][63:32], wdata, wstrb);
                    16'hBFF8: t[31:0]  = merge(t[31:0], wdata, wstrb);
                    16'hBFFC: t[63:32] = merge(t[63:32], wdata, wstrb);
                    default: ;
                endcase
            end
        end
        n_time[i] = t;
        n_mtip[i] = (t >= n_cmp[i]);
    endtask

    task automatic cycle(logic av, logic [31:0] aa, logic awv, logic wv, logic [31:0] wa,
                         logic [31:0] wd, logic [3:0] ws);
        arvalid = av; araddr = aa; awvalid = awv; wvalid = wv; awaddr = wa; wdata = wd;
        wstrb = ws;
        for (int i = 0; i < 2; i++) model_step(i);
        @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            m_time[i] = n_time[i]; m_cmp[i] = n_cmp[i]; m_msip[i] = n_msip[i];
            m_mtip[i] = n_mtip[i]; m_pre[i] = n_pre[i];
        end
        @(negedge clock);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0);
    endtask

    task automatic wr(logic [15:0] off, logic [31:0] d, logic [3:0] s);
        cycle(1'b0, '0, 1'b1, 1'b1, BASE | {16'd0, off}, d, s);
    endtask

    task automatic rd(logic [15:0] off);
        cycle(1'b1, BASE | {16'd0, off}, 1'b0, 1'b0, '0, '0, 4'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] lo;
        lo = 32'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
            0: return BASE | lo;
            1: return (BASE + 32'h4000) | lo;
            2: return (BASE + 32'h4004) | lo;
            3: return (BASE + 32'hBFF8) | lo;
            4: return (BASE + 32'hBFFC) | lo;
            5: return BASE + 32'h8000;
            6: return BASE | 32'($urandom_range(0, 32'hFFFF));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: sample 1 time unit after each active edge.
    always @(posedge clock) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                chk("rvalid_in_reset", i, 64'(rvalid_o[i]), 64'd0);
                chk("wready_in_reset", i, 64'(wready_o[i]), 64'd0);
            end else begin
                if (rq[i].size() > 0) begin
                    logic [31:0] exp_r;
                    exp_r = rq[i].pop_front();
                    chk("rvalid", i, 64'(rvalid_o[i]), 64'd1);
                    chk("rdata", i, 64'(rdata_o[i]), 64'(exp_r));
                end else begin
                    chk("rvalid_idle", i, 64'(rvalid_o[i]), 64'd0);
                end
                if (wq[i].size() > 0) begin
                    void'(wq[i].pop_front());
                    chk("wready", i, 64'(wready_o[i]), 64'd1);
                end else begin
                    chk("wready_idle", i, 64'(wready_o[i]), 64'd0);
                end
                chk("mtime", i, mtime_o[i], m_time[i]);
                chk("mtip", i, 64'(mtip_o[i]), 64'(m_mtip[i]));
                chk("msip", i, 64'(msip_o[i]), 64'(m_msip[i]));
            end
        end
    end

    initial begin
        #1;
        do_reset();
        idle(6);                                   // free-running count
        wr(16'h0000, 32'h1, 4'hF);                 // msip set
        rd(16'h0000);
        idle(2);

        do_reset();
        wr(16'h4004, 32'd0, 4'hF);
        wr(16'h4000, 32'd20, 4'hF);                // mtip rises as mtime reaches 20
        idle(24);
        wr(16'h4000, 32'd100, 4'hF);               // mtip falls at this write
        idle(3);

        do_reset();
        wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);         // lower-half carry into upper half
        idle(5);
        rd(16'hBFFC);
        idle(2);

        do_reset();
        cycle(1'b1, BASE + 32'h4000, 1'b1, 1'b1, BASE + 32'h4000, 32'h1234, 4'h3);
        rd(16'h4000);
        rd(16'h8000);                              // unmapped offset reads zero
        cycle(1'b1, 32'h1000_0000, 1'b1, 1'b1, 32'h1000_0000, 32'hDEAD, 4'hF);

        // Reset asserted while a read is pending at the next edge: no response.
        arvalid = 1'b1;
        araddr  = BASE + 32'hBFF8;
        #2;
        reset   = 1'b1;
        model_reset();
        arvalid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle(3);

        for (int k = 0; k < 800; k++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 600));
            cycle(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), rand_addr(), d, 4'($urandom_range(0, 15)));
        end
        idle(2);

        for (int i = 0; i < 2; i++) begin
            chk("rq_drained", i, 64'(rq[i].size()), 64'd0);
            chk("wq_drained", i, 64'(wq[i].size()), 64'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
